fetch_byte_queue: RTL
=====================

Name: fetch_byte_queue

Overview:
- Instruction-fetch stage between the ICache and the Decoder.
- Requests 64-byte lines from the ICache and packs the bytes from the current RIP onward into a byte FIFO.
- Presents a 15-byte window plus its RIP to the Decoder and retires however many bytes the Decoder reports as consumed.
- Handles RIP redirects (reset entry, later branches) by flushing and refetching.

Parameters:
- LINE_BYTES, 64, ICache line size in bytes; power of two.
- WIN_BYTES, 15, decode window size in bytes (maximum x86 instruction length).
- QUEUE_BYTES, 128, FIFO capacity in bytes; power of two, at least LINE_BYTES + WIN_BYTES.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- set_rip  in  1  redirect strobe; flush and restart fetch at new_rip.
- new_rip  in  64  redirect target.
- icache_enable  out  1  line request; held until icache_done.
- icache_addr  out  64  line-aligned request address.
- icache_rdata  in  LINE_BYTES*8  line data; byte i at bits [8i+7:8i].
- icache_done  in  1  one-cycle completion pulse.
- decode_bytes  out  WIN_BYTES*8  window; byte 0 in the MSBs ([0:7], big-endian vector).
- decode_rip  out  64  address of decode_bytes byte 0.
- if_dc  out  1  window valid.
- bytes_decoded  in  8  bytes consumed this cycle; only sampled when if_dc=1.

Behaviour:
- Reset (asynchronous, reset=0):
  - State IDLE.
  - All outputs 0; FIFO empty (count=0, rd/wr pointers 0).
  - Internal fetch_addr=0.
  - No fetch starts until the first set_rip.
- State machine:
  - IDLE: set_rip moves to FETCH.
  - FETCH: icache_enable=1, icache_addr={fetch_addr[63:6],6'b0}. Waits for icache_done. On done:
    - Push bytes from offset fetch_addr[5:0] through byte 63 into the FIFO (64-off bytes, in a single cycle).
    - fetch_addr <= line base + 64; enter WAIT.
  - WAIT: icache_enable=0. Returns to FETCH on the next cycle in which free space (QUEUE_BYTES - count) >= LINE_BYTES.
  - DISCARD: entered when set_rip arrives in FETCH before done. Holds icache_enable and icache_addr stable until icache_done, drops that data, then goes to FETCH at the new target.
- icache_enable never deasserts mid-request; icache_addr is stable while enable=1.
- Redirect (set_rip=1), effective the same edge:
  - FIFO flushed; decode_rip <= new_rip; fetch_addr <= new_rip.
  - if_dc is 0 the following cycle.
  - Any push or pop in that cycle is cancelled.
  - Next state: FETCH from IDLE/WAIT; DISCARD from FETCH (whether or not icache_done is also high that cycle); DISCARD stays DISCARD.
- Decode window:
  - if_dc = (count >= WIN_BYTES) and no set_rip this cycle. Registered, so it reflects post-edge count.
  - decode_bytes = FIFO bytes [rd_ptr .. rd_ptr+14], modulo QUEUE_BYTES. Zero when if_dc=0.
- Consume:
  - When if_dc=1, pop n = min(bytes_decoded, WIN_BYTES); rd_ptr += n; decode_rip += n (64-bit wrap).
  - bytes_decoded=0 holds the window. bytes_decoded > 15 is clamped to 15.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. Both take effect.
- Pointer wrap: rd_ptr/wr_ptr are log2(QUEUE_BYTES) bits and wrap naturally; full is count == QUEUE_BYTES. WAIT guarantees a push never overflows.
- icache_done outside FETCH/DISCARD is ignored.
- Reset mid-request: the request is abandoned; a late icache_done is ignored (state IDLE).

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - Adds outputs stat_lines[31:0] (lines pushed, excluding discarded) and stat_starve[31:0] (cycles with if_dc=0 while state != IDLE).
  - Both counters are saturating, zeroed by reset, and not cleared by set_rip.
  - $display of both at final.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, set_rip with new_rip=0x1000, ICache returns line at 0x1000 after 3 cycles -> icache_addr=0x1000; one cycle after done, if_dc=1, decode_rip=0x1000, decode_bytes = line bytes 0..14.
- Unaligned redirect to 0x103A -> only 6 bytes pushed, if_dc stays 0; second request addr=0x1040; after it, window = bytes 0x3A..0x3F of line 0 followed by bytes 0..8 of line 1.
- Steady consume of 4 bytes/cycle from 0x2000 -> decode_rip increments by 4 each cycle. After the first line is pushed, count reaches 64 and the queue requests 0x2040 immediately (free 64). Line requests continue with no bubble in if_dc once the ICache latency is covered.
- set_rip to 0x3000 while a request for 0x2080 is outstanding -> enable held with addr 0x2080 until done, data dropped, then request 0x3000; if_dc=0 until 0x3000 bytes arrive.
- Decoder stalls (bytes_decoded=0) -> fills to 128 bytes, enable stays 0 in WAIT; consuming 15 leaves 113 bytes (free 15) and enable stays 0 until free >= 64 (count <= 64).
- Assert reset mid-request -> all outputs 0 asynchronously; a subsequent icache_done pulse causes no push and if_dc stays 0.

Source files
------------

// File: rtl/fetch_byte_queue_if.sv
// Fetch-stage bus: redirect, ICache line request and decode window.
// master = fetch queue side, slave = ICache/decoder/redirect side.
interface fetch_byte_queue_if #(
  parameter int LINE_BYTES = 64,
  parameter int WIN_BYTES  = 15
);
  logic                    set_rip;
  logic [63:0]             new_rip;
  logic                    icache_enable;
  logic [63:0]             icache_addr;
  logic [LINE_BYTES*8-1:0] icache_rdata;
  logic                    icache_done;
  logic [WIN_BYTES*8-1:0]  decode_bytes;
  logic [63:0]             decode_rip;
  logic                    if_dc;
  logic [7:0]              bytes_decoded;

  modport master (
    input  set_rip, new_rip,
    input  icache_rdata, icache_done,
    input  bytes_decoded,
    output icache_enable, icache_addr,
    output decode_bytes, decode_rip, if_dc
  );

  modport slave (
    output set_rip, new_rip,
    output icache_rdata, icache_done,
    output bytes_decoded,
    input  icache_enable, icache_addr,
    input  decode_bytes, decode_rip, if_dc
  );
endinterface

// File: rtl/fetch_byte_queue.sv
// Fetch byte queue: ICache lines -> byte FIFO -> 15-byte decode window.
// Optional FETCH_STATS_EN adds saturating line/starvation counters.
module fetch_byte_queue #(
  parameter int LINE_BYTES  = 64,
  parameter int WIN_BYTES   = 15,
  parameter int QUEUE_BYTES = 128
) (
  input  logic clk,
  input  logic reset,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_lines,
  output logic [31:0] stat_starve,
`endif
  fetch_byte_queue_if.master bus
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE, FETCH, WAIT, DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_addr_q, fetch_addr_d;
  logic [63:0]   req_addr_q, req_addr_d;
  logic [63:0]   rip_q, rip_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          if_dc_q, if_dc_d;
  logic [7:0]    mem_q [QUEUE_BYTES];

  logic [OW-1:0] off;
  logic [63:0]   line_base;
  logic          push, pop;
  logic [7:0]    take;
  logic [CW-1:0] push_n, pop_n, free;

  always_comb begin
    off       = fetch_addr_q[OW-1:0];
    line_base = {fetch_addr_q[63:OW], {OW{1'b0}}};
    push      = (state_q == FETCH) && bus.icache_done
                && !bus.set_rip;
    pop       = if_dc_q && !bus.set_rip;
    take      = (bus.bytes_decoded > 8'(WIN_BYTES))
                ? 8'(WIN_BYTES) : bus.bytes_decoded;
    push_n    = push ? CW'(LINE_BYTES) - CW'(off) : '0;
    pop_n     = pop ? CW'(take) : '0;
    free      = CW'(QUEUE_BYTES) - count_q;
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    rip_d        = rip_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if_dc_d      = if_dc_q;
    if (bus.set_rip) begin
      fetch_addr_d = bus.new_rip;
      rip_d        = bus.new_rip;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      if_dc_d      = 1'b0;
      // an outstanding request must finish before refetching
      if (state_q == FETCH) req_addr_d = line_base;
      if (state_q == FETCH || state_q == DISCARD)
        state_d = DISCARD;
      else
        state_d = FETCH;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      count_d  = count_q + push_n - pop_n;
      rip_d    = rip_q + 64'(pop_n);
      if_dc_d  = count_d >= CW'(WIN_BYTES);
      unique case (state_q)
        IDLE: ;
        FETCH:
          if (bus.icache_done) begin
            fetch_addr_d = line_base + 64'(LINE_BYTES);
            state_d      = WAIT;
          end
        WAIT:
          if (free >= CW'(LINE_BYTES)) state_d = FETCH;
        DISCARD:
          if (bus.icache_done) state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    bus.icache_enable = (state_q == FETCH)
                        || (state_q == DISCARD);
    bus.icache_addr   = '0;
    if (state_q == FETCH)   bus.icache_addr = line_base;
    if (state_q == DISCARD) bus.icache_addr = req_addr_q;
    bus.decode_rip    = rip_q;
    bus.if_dc         = if_dc_q;
    bus.decode_bytes  = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      if (if_dc_q)
        bus.decode_bytes[(WIN_BYTES-1-k)*8 +: 8] =
          mem_q[rd_ptr_q + PW'(k)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
      rip_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      if_dc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      rip_q        <= rip_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      if_dc_q      <= if_dc_d;
    end
  end

  // bytes below the fetch offset are skipped
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (OW'(i) >= off)
          mem_q[wr_ptr_q + PW'(i) - PW'(off)] <=
            bus.icache_rdata[8*i +: 8];
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] lines_q, lines_d;
  logic [31:0] starve_q, starve_d;

  always_comb begin
    lines_d  = lines_q;
    starve_d = starve_q;
    if (push && lines_q != '1)
      lines_d = lines_q + 32'd1;
    if (!if_dc_q && state_q != IDLE && starve_q != '1)
      starve_d = starve_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lines_q  <= '0;
      starve_q <= '0;
    end else begin
      lines_q  <= lines_d;
      starve_q <= starve_d;
    end
  end

  assign stat_lines  = lines_q;
  assign stat_starve = starve_q;

  final $display("fetch_byte_queue: lines=%0d starve=%0d",
                 lines_q, starve_q);
`endif
endmodule
